uart_tx: RTL and testbench

- UART transmitter: serialises parallel words onto `txd` as 8N1-style frames (start, DATA_WIDTH data bits LSB-first, one stop bit).
- Bit period comes from a runtime 16-bit `prescale` (clock cycles per bit), the same encoding the receive path uses.
- Sits between the AXI-Lite register/FIFO layer and the pad.
- Word intake is a valid/ready handshake.

---
 rtl/uart_tx.sv | 174 +++++++++++++++++
 tb/tb_uart_tx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. It sends each word as one frame: a start bit,
// DATA_WIDTH data bits LSB-first, and one stop bit.
//
// Each bit lasts P clock cycles. P is the 16-bit prescale value, latched
// when the word is accepted. A prescale of 0 is treated as P = 1.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
//
// Ports:
//   clk       system clock; all logic runs on the rising edge
//   rst       synchronous, active-high reset
//   tx_data   word to transmit; sampled only on the handshake
//   tx_valid  tx_data holds a valid word
//   tx_ready  the transmitter can accept a word (idle and not in reset)
//   prescale  clock cycles per bit; sampled only on the handshake
//   txd       serial line, idle high, driven from a register
//   busy      a frame is in progress
//   tx_done   one-cycle pulse when the stop bit completes
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [15:0]           prescale,
    output logic                  txd,
    output logic                  busy,
    output logic                  tx_done
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_STOP  = 3'd4
    } state_t;
`endif

    localparam logic [4:0] LAST_BIT = 5'(DATA_WIDTH - 1);

    state_t                  state, state_n;
    logic [15:0]             timer, timer_n;
    logic [15:0]             period, period_n;
    logic [4:0]              bit_cnt, bit_cnt_n;
    logic [DATA_WIDTH-1:0]   shifter, shifter_n;
    logic                    txd_n, done_n;
    logic [15:0]             p_eff;
`ifdef UART_TX_PARITY_EN
    logic                    parity, parity_n;
`endif

    assign tx_ready = (state == TX_IDLE) && !rst;
    assign busy     = (state != TX_IDLE);
    // A prescale of 0 would give a zero-length bit, so it is clamped to 1.
    assign p_eff    = (prescale == 16'd0) ? 16'd1 : prescale;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= TX_IDLE;
            timer   <= 16'd0;
            period  <= 16'd0;
            bit_cnt <= 5'd0;
            shifter <= '0;
            txd     <= 1'b1;
            tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            period  <= period_n;
            bit_cnt <= bit_cnt_n;
            shifter <= shifter_n;
            txd     <= txd_n;
            tx_done <= done_n;
`ifdef UART_TX_PARITY_EN
            parity  <= parity_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        timer_n   = timer;
        period_n  = period;
        bit_cnt_n = bit_cnt;
        shifter_n = shifter;
        txd_n     = txd;
        done_n    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_n  = parity;
`endif
        // The timer counts down from P-1 to 0, so every bit lasts exactly
        // P cycles. While it is non-zero it only decrements.
        if (state != TX_IDLE && timer != 16'd0)
            timer_n = timer - 16'd1;

        case (state)
            TX_IDLE: begin
                txd_n = 1'b1;
                if (tx_valid && tx_ready) begin
                    shifter_n = tx_data;
                    period_n  = p_eff;
                    timer_n   = p_eff - 16'd1;
                    txd_n     = 1'b0;
                    state_n   = TX_START;
`ifdef UART_TX_PARITY_EN
                    parity_n  = ^tx_data;
`endif
                end
            end
            TX_START: begin
                if (timer == 16'd0) begin
                    state_n   = TX_DATA;
                    timer_n   = period - 16'd1;
                    bit_cnt_n = 5'd0;
                    txd_n     = shifter[0];
                end
            end
            TX_DATA: begin
                if (timer == 16'd0) begin
                    shifter_n = shifter >> 1;
                    timer_n   = period - 16'd1;
                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_n = TX_PARITY;
                        txd_n   = parity;
`else
                        state_n = TX_STOP;
                        txd_n   = 1'b1;
`endif
                    end else begin
                        bit_cnt_n = bit_cnt + 5'd1;
                        txd_n     = shifter_n[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY: begin
                if (timer == 16'd0) begin
                    state_n = TX_STOP;
                    timer_n = period - 16'd1;
                    txd_n   = 1'b1;
                end
            end
`endif
            TX_STOP: begin
                txd_n = 1'b1;
                if (timer == 16'd0) begin
                    state_n = TX_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = TX_IDLE;
                txd_n   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
//
// Each accepted word pushes a {data, P} record into a scoreboard queue. A
// separate monitor detects each start bit, pops the matching record and
// builds the expected bit list (start, data LSB-first, optional parity,
// stop). It then checks txd on every cycle of the frame, and checks the
// tx_done pulse and idle line that follow.
module tb_uart_tx;
    localparam int DW      = 8;
    localparam int TIMEOUT = 3000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic [15:0]   prescale = 16'd1;
    logic          tx_ready, txd, busy, tx_done;

    uart_tx #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .prescale(prescale), .txd(txd), .busy(busy),
        .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            p;
    } frame_t;

    frame_t exp_q[$];
    int     vectors = 0;
    int     miscompares = 0;
    int     cyc = 0;
    bit     mon_active = 0;

    always @(posedge clk) cyc <= cyc + 1;

`ifdef UART_TX_PARITY_EN
    localparam int NBITS = DW + 3;
`else
    localparam int NBITS = DW + 2;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Call this just after a rising edge. It returns just after the
    // accepting edge and reports the cycle count at acceptance.
    task automatic send(input logic [DW-1:0] d, input logic [15:0] p,
                        input bit hold, output int acc);
        logic rdy;
        int   t;
        frame_t f;
        tx_data  = d;
        prescale = p;
        tx_valid = 1'b1;
        t = 0;
        acc = -1;
        while (1) begin
            @(negedge clk);
            rdy = tx_ready;
            @(posedge clk);
            if (rdy) break;
            t++;
            if (t > TIMEOUT) begin
                chk("accept_timeout", 32'd0, 32'd1);
                #1 tx_valid = 1'b0;
                return;
            end
        end
        f.data = d;
        f.p    = (p == 16'd0) ? 1 : int'(p);
        exp_q.push_back(f);
        #1;
        acc = cyc;
        if (!hold) tx_valid = 1'b0;
    endtask

    // Monitor: compares the line against the scoreboard head.
    initial begin
        frame_t e;
        bit     bits[$];
        bit     aborted;
        forever begin
            @(negedge clk);
            if (rst) continue;
            if (txd === 1'b0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 32'd1, 32'd0);
                    continue;
                end
                mon_active = 1;
                e = exp_q.pop_front();
                bits.delete();
                bits.push_back(1'b0);
                for (int i = 0; i < DW; i++) bits.push_back(e.data[i]);
`ifdef UART_TX_PARITY_EN
                bits.push_back(^e.data);
`endif
                bits.push_back(1'b1);
                aborted = 0;
                for (int s = 0; s < NBITS * e.p; s++) begin
                    if (s > 0) @(negedge clk);
                    if (rst) begin aborted = 1; break; end
                    chk("txd", 32'(txd), 32'(bits[s / e.p]));
                    chk("busy_in_frame", 32'(busy), 32'd1);
                    chk("ready_in_frame", 32'(tx_ready), 32'd0);
                    chk("done_in_frame", 32'(tx_done), 32'd0);
                end
                if (!aborted) begin
                    @(negedge clk);
                    if (!rst) begin
                        chk("tx_done_pulse", 32'(tx_done), 32'd1);
                        chk("txd_after_stop", 32'(txd), 32'd1);
                    end
                end
                mon_active = 0;
            end else begin
                chk("done_while_idle", 32'(tx_done), 32'd0);
            end
        end
    end

    initial begin
        int a1, a2, gap, n;
        logic [15:0] p;
        bit hold;

        // Reset behaviour.
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("rst_txd", 32'(txd), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(tx_done), 32'd0);
            chk("rst_ready", 32'(tx_ready), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(tx_ready), 32'd1);
        chk("post_rst_txd", 32'(txd), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // prescale=4, 0x55.
        send(8'h55, 16'd4, 0, a1);
        repeat (45) @(posedge clk);
        #1;

        // prescale=1, back-to-back with tx_valid held high.
        send(8'hA3, 16'd1, 1, a1);
        send(8'h0F, 16'd1, 0, a2);
        chk("b2b_spacing_p1", 32'(a2 - a1), 32'(NBITS * 1 + 1));
        repeat (15) @(posedge clk);
        #1;

        // Data and prescale change mid-frame; the next frame uses 8.
        send(8'h3C, 16'd4, 1, a1);
        send(8'hC5, 16'd8, 0, a2);
        chk("b2b_spacing_p4", 32'(a2 - a1), 32'(NBITS * 4 + 1));
        repeat (NBITS * 8 + 4) @(posedge clk);
        #1;

        // Reset during data bit 3 of a prescale=16 frame.
        send(8'h96, 16'd16, 0, a1);
        repeat (4 * 16 + 5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_txd", 32'(txd), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(tx_done), 32'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        send(8'hFF, 16'd3, 0, a1);
        repeat (NBITS * 3 + 4) @(posedge clk);
        #1;

`ifdef UART_TX_PARITY_EN
        send(8'h07, 16'd2, 0, a1);
        repeat (NBITS * 2 + 4) @(posedge clk);
        #1;
`endif

        // Random frames, including prescale 0, gaps and held valid.
        for (int k = 0; k < 24; k++) begin
            p    = 16'($urandom_range(0, 6));
            hold = (k != 23) && ($urandom_range(0, 3) == 0);
            send(DW'($urandom), p, hold, a1);
            if (!hold) begin
                gap = $urandom_range(0, 3);
                repeat (gap) @(posedge clk);
                #1;
            end
        end

        // Drain the scoreboard.
        n = 0;
        while ((exp_q.size() != 0 || mon_active || busy) && n < TIMEOUT) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_timeout", 32'(n < TIMEOUT), 32'd1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
